// File: rtl/result_collector_if.sv
// result_collector_if: producer pulse, consumer valid/ready and status signals of the result collector.
interface result_collector_if #(
   parameter int WIDTH = 16,
   parameter int PTR_W = 2
);
   logic             output_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             full;
   logic             almost_full;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             clr_overflow;
   modport slave (
      input  output_valid, result, out_ready, clr_overflow,
      output out_data, out_valid, full, almost_full, count, overflow
   );
   modport master (
      output output_valid, result, out_ready, clr_overflow,
      input  out_data, out_valid, full, almost_full, count, overflow
   );
endinterface

// File: rtl/result_collector.sv
// result_collector: buffers finished results in a first-word-fall-through FIFO,
// hands them out over valid/ready and flags dropped results with a sticky overflow.
module result_collector #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic               clock,
   input logic               reset,
   result_collector_if.slave bus
);
   localparam logic [PTR_W:0] full_cnt = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] af_cnt   = (PTR_W+1)'(DEPTH-1);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow, full, push, pop, drop;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
   always_comb begin
      full = count == full_cnt;
      pop  = count != '0 && bus.out_ready;
      push = bus.output_valid && (!full || pop);
      drop = bus.output_valid && full && !pop;
   end
   assign bus.out_data    = mem[rd_ptr];
   assign bus.out_valid   = count != '0;
   assign bus.full        = full;
   assign bus.almost_full = count >= af_cnt;
   assign bus.count       = count;
   assign bus.overflow    = overflow;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) mem[wr_ptr] <= bus.result;
         wr_ptr   <= wr_ptr + PTR_W'(push);
         rd_ptr   <= rd_ptr + PTR_W'(pop);
         count    <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
         overflow <= drop || (overflow && !bus.clr_overflow);
      end
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: directed and random stimulus against a queue-based model of the result FIFO.
module tb_result_collector;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] q[$];
   logic m_ovf = 1'b0;
   result_collector_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus();
   result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );
   always #5 clock = ~clock;
   function automatic logic [PTR_W:0] ec();
      return (PTR_W+1)'(q.size());
   endfunction
   // Drives one cycle of inputs and advances the model by the FIFO rules.
   task automatic step(input logic ov, input logic [WIDTH-1:0] res, input logic rdy, input logic clr);
      bit pop, full;
      bus.output_valid = ov;
      bus.result       = res;
      bus.out_ready    = rdy;
      bus.clr_overflow = clr;
      pop  = rdy && q.size() > 0;
      full = q.size() == DEPTH;
      if (pop) void'(q.pop_front());
      if (ov && full && !pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (ov && !(full && !pop)) q.push_back(res);
      @(posedge clock);
      #1;
      bus.output_valid = 1'b0;
      bus.out_ready    = 1'b0;
      bus.clr_overflow = 1'b0;
   endtask
   task automatic test_reset();
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got %h expected 0000", bus.out_data); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", bus.count); end
      checks++; if ({bus.full, bus.almost_full, bus.overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {bus.full, bus.almost_full, bus.overflow}); end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask
   task automatic test_single();
      bus.output_valid = 1'b1;
      bus.result = 16'h1234;
      #2;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_bypass got %b expected 0", bus.out_valid); end
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h1234) begin errors++; $display("FAIL single_out got %b/%h expected 1/1234", bus.out_valid, bus.out_data); end
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d expected 1", bus.count); end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %0d/%b expected 0/0", bus.count, bus.out_valid); end
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL empty_ready got %0d expected 0", bus.count); end
   endtask
   task automatic test_fill_drain();
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, WIDTH'(i), 1'b0, 1'b0);
         checks++; if (bus.almost_full !== (i >= 3)) begin errors++; $display("FAIL fill_af push %0d got %b expected %b", i, bus.almost_full, i >= 3); end
         checks++; if (bus.full !== (i == 4) || bus.count !== ec()) begin errors++; $display("FAIL fill_full push %0d got %b/%0d expected %b/%0d", i, bus.full, bus.count, i == 4, ec()); end
      end
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL hold_data got %h expected 0001", bus.out_data); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus.out_data !== WIDTH'(i)) begin errors++; $display("FAIL drain_order got %h expected %h", bus.out_data, WIDTH'(i)); end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d expected 0", bus.count); end
   endtask
   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      step(1'b1, 16'h00AA, 1'b0, 1'b0);
      checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL ovf_set got %b/%0d expected 1/4", bus.overflow, bus.count); end
      for (int i = 1; i <= 4; i++) begin
         checks++; if (bus.out_data !== WIDTH'(i)) begin errors++; $display("FAIL ovf_order got %h expected %h", bus.out_data, WIDTH'(i)); end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", bus.overflow); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b expected 0", bus.overflow); end
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      step(1'b1, 16'h00BB, 1'b0, 1'b1);
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b expected 1", bus.overflow); end
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
   endtask
   task automatic test_full_push_pop();
      for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0);
      checks++; if (bus.out_data !== 16'h0001) begin errors++; $display("FAIL fpp_head got %h expected 0001", bus.out_data); end
      step(1'b1, 16'h0005, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fpp_count got %0d/%b expected 4/0", bus.count, bus.overflow); end
      for (int i = 2; i <= 5; i++) begin
         checks++; if (bus.out_data !== WIDTH'(i)) begin errors++; $display("FAIL fpp_order got %h expected %h", bus.out_data, WIDTH'(i)); end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL fpp_empty got %0d expected 0", bus.count); end
   endtask
   task automatic test_wrap();
      logic [WIDTH-1:0] got[$];
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) got.push_back(bus.out_data);
         step(1'b1, WIDTH'(16'h0100 + i), 1'b1, 1'b0);
         if (i % 3 == 2) begin
            got.push_back(bus.out_data);
            step(1'b0, '0, 1'b1, 1'b0);
         end
      end
      while (bus.out_valid && got.size() < 12) begin
         got.push_back(bus.out_data);
         step(1'b0, '0, 1'b1, 1'b0);
      end
      checks++; if (got.size() !== 10) begin errors++; $display("FAIL wrap_len got %0d expected 10", got.size()); end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         checks++; if (got[i] !== WIDTH'(16'h0100 + i)) begin errors++; $display("FAIL wrap_val %0d got %h expected %h", i, got[i], WIDTH'(16'h0100 + i)); end
      end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_count got %0d expected 0", bus.count); end
   endtask
   task automatic test_random();
      logic ov, rdy, clr;
      logic [WIDTH-1:0] res;
      for (int n = 0; n < 300; n++) begin
         ov  = $urandom_range(1) == 1;
         rdy = $urandom_range(2) == 0;
         clr = $urandom_range(9) == 0;
         res = WIDTH'($urandom);
         if (q.size() > 0) begin
            checks++; if (bus.out_data !== q[0]) begin errors++; $display("FAIL rand_data cyc %0d got %h expected %h", n, bus.out_data, q[0]); end
         end
         step(ov, res, rdy, clr);
         checks++; if (bus.count !== ec() || bus.out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_count cyc %0d got %0d/%b expected %0d", n, bus.count, bus.out_valid, ec()); end
         checks++; if (bus.full !== (q.size() == DEPTH) || bus.almost_full !== (q.size() >= DEPTH-1)) begin errors++; $display("FAIL rand_flags cyc %0d got %b%b size %0d", n, bus.full, bus.almost_full, q.size()); end
         checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b expected %b", n, bus.overflow, m_ovf); end
      end
   endtask
   task automatic test_reset_mid();
      while (q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(16'h0010 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      checks++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%b expected 3/1", bus.count, bus.overflow); end
      reset = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_async got %b/%0d/%b expected 0/0/0", bus.out_valid, bus.count, bus.overflow); end
      q.delete();
      m_ovf = 1'b0;
      bus.output_valid = 1'b1;
      bus.result = 16'hDEAD;
      @(posedge clock);
      #1;
      bus.output_valid = 1'b0;
      reset = 1'b0;
      checks++; if (bus.count !== 3'd0 || bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_lost got %0d/%b expected 0/0", bus.count, bus.overflow); end
      step(1'b1, 16'hBEEF, 1'b0, 1'b0);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hBEEF || bus.count !== 3'd1) begin errors++; $display("FAIL mid_after got %b/%h/%0d expected 1/beef/1", bus.out_valid, bus.out_data, bus.count); end
   endtask
   initial begin
      bus.output_valid = 1'b0;
      bus.result       = '0;
      bus.out_ready    = 1'b0;
      bus.clr_overflow = 1'b0;
      test_reset();
      test_single();
      test_fill_drain();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule
